// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and encodings used by the EX-stage blocks
// (shift unit, shift-operand fixup, ALU decode).
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef enum logic [1:0] {
    SK_SLL = 2'd0,
    SK_SRL = 2'd1,
    SK_SRA = 2'd2
  } shift_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shift_state_t;

  function automatic logic is_shift_insn(input logic [6:0] op, input logic [2:0] func3);
    return ((op == OP_RTYPE) || (op == OP_ITYPE)) &&
           ((func3 == F3_SLL) || (func3 == F3_SR));
  endfunction

  function automatic shift_kind_t decode_shift_kind(input logic [2:0] func3,
                                                    input logic       func7_5);
    if (func3 == F3_SLL) return SK_SLL;
    return func7_5 ? SK_SRA : SK_SRL;
  endfunction

endpackage

// File: rtl/ex_shift_unit_shift_step.sv
// One combinational shift step: shifts value by amount (0..STEP) in the
// direction and fill mode selected by kind.
module shift_step
  import riscv_pkg::*;
(
  input  logic [31:0]  value,
  input  logic [5:0]   amount,
  input  shift_kind_t  kind,
  output logic [31:0]  shifted
);

  always_comb begin
    shifted = value;
    case (kind)
      SK_SLL:  shifted = value << amount;
      SK_SRL:  shifted = value >> amount;
      SK_SRA:  shifted = $unsigned($signed(value) >>> amount);
      default: shifted = value;
    endcase
  end

endmodule

// File: rtl/ex_shift_unit.sv
// Multi-cycle EX-stage shifter: shifts at most STEP bits per cycle, stalls the
// pipeline while working, then pulses done with the registered result.
module ex_shift_unit
  import riscv_pkg::*;
#(
  parameter int unsigned STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [6:0]  op,
  input  logic [2:0]  func3,
  input  logic        func7_5,
  input  logic [31:0] operand_a,
  input  logic [31:0] shamt_src,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        stall
);

  localparam logic [5:0] STEP_W = 6'(STEP);

  shift_state_t state, state_nx;
  shift_kind_t  kind;
  logic [31:0]  acc;
  logic [5:0]   cnt;
  logic [5:0]   step_amt;
  logic [31:0]  step_out;
  logic         accept;
  logic         last_step;
  logic         unused_shamt_hi;

  assign unused_shamt_hi = ^shamt_src[31:5];

  assign accept    = start & is_shift_insn(op, func3) & (state == ST_IDLE) & ~flush;
  assign step_amt  = (cnt < STEP_W) ? cnt : STEP_W;
  // Decided on the count before this cycle's step: the step taken now finishes it.
  assign last_step = (cnt <= STEP_W);

  assign busy  = (state != ST_IDLE);
  assign stall = accept | (state == ST_SHIFT);
  assign done  = (state == ST_DONE) & ~flush;

  shift_step u_shift_step (
    .value   (acc),
    .amount  (step_amt),
    .kind    (kind),
    .shifted (step_out)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_SHIFT;
      ST_SHIFT: if (last_step) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    if (flush) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      acc    <= '0;
      cnt    <= '0;
      kind   <= SK_SLL;
      result <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        acc  <= operand_a;
        cnt  <= {1'b0, shamt_src[4:0]};
        kind <= decode_shift_kind(func3, func7_5);
      end else if ((state == ST_SHIFT) && !flush) begin
        acc <= step_out;
        cnt <= cnt - step_amt;
        if (last_step) result <= step_out;
      end
    end
  end

endmodule

// File: tb/tb_ex_shift_unit.sv
// Self-checking bench for ex_shift_unit (STEP = 4): directed cases plus
// randomized instructions compared against an arithmetic reference model.
module tb_ex_shift_unit;

  localparam int unsigned STEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [6:0]  op = '0;
  logic [2:0]  func3 = '0;
  logic        func7_5 = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] shamt_src = '0;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        stall;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_result = '0;

  always #5 clk = ~clk;

  ex_shift_unit #(.STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .flush     (flush),
    .op        (op),
    .func3     (func3),
    .func7_5   (func7_5),
    .operand_a (operand_a),
    .shamt_src (shamt_src),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .stall     (stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_is_shift(input logic [6:0] o, input logic [2:0] f3);
    return (o == 7'b0110011 || o == 7'b0010011) && (f3 == 3'b001 || f3 == 3'b101);
  endfunction

  function automatic logic [31:0] model_shift(input logic [2:0] f3, input logic f7,
                                              input logic [31:0] a, input int s);
    longint signed sa;
    if (f3 == 3'b001) return a << s;
    if (!f7) return a >> s;
    sa = longint'($signed(a));
    return 32'(sa / (longint'(1) << s) - ((sa < 0 && (sa % (longint'(1) << s)) != 0) ? 1 : 0));
  endfunction

  function automatic int model_latency(input int s);
    int c;
    c = (s + int'(STEP) - 1) / int'(STEP);
    return 1 + ((c < 1) ? 1 : c);
  endfunction

  // Issue one instruction; the start cycle begins at the next posedge.
  // During busy the pipeline keeps start high while operand_a is scrambled.
  task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] src);
    int s, lat;
    bit sh;
    logic [31:0] exp_val;
    s = int'(src[4:0]);
    sh = model_is_shift(o, f3);
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b0; op = o; func3 = f3; func7_5 = f7;
    operand_a = a; shamt_src = src;
    @(negedge clk);
    check("t0_stall", 32'(stall), 32'(sh));
    check("t0_busy", 32'(busy), 32'd0);
    check("t0_done", 32'(done), 32'd0);
    check("t0_result", result, exp_result);
    if (!sh) begin
      for (int k = 1; k <= 3; k++) begin
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("ns_busy", 32'(busy), 32'd0);
        check("ns_stall", 32'(stall), 32'd0);
        check("ns_done", 32'(done), 32'd0);
        check("ns_result", result, exp_result);
      end
      return;
    end
    lat = model_latency(s);
    exp_val = model_shift(f3, f7, a, s);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      operand_a = $urandom;
      shamt_src = $urandom;
      if (k == lat) start = 1'b0;
      @(negedge clk);
      check("done", 32'(done), 32'(k == lat));
      check("busy", 32'(busy), 32'd1);
      check("stall", 32'(stall), 32'(k < lat));
      if (k == lat) begin
        exp_result = exp_val;
        check("result", result, exp_result);
      end
    end
  endtask

  initial begin
    #2;
    @(negedge clk);
    check("rst_result", result, 32'h0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;

    issue(7'b0110011, 3'b001, 1'b0, 32'h0000_0001, 32'd31);
    check("sll31", result, 32'h8000_0000);
    issue(7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'h0000_0404);
    check("srai4", result, 32'hF800_0000);
    issue(7'b0010011, 3'b101, 1'b0, 32'h8000_0000, 32'h0000_0404);
    check("srli4", result, 32'h0800_0000);
    issue(7'b0110011, 3'b101, 1'b0, 32'hDEAD_BEEF, 32'd0);
    check("srl0", result, 32'hDEAD_BEEF);
    issue(7'b0110011, 3'b000, 1'b0, 32'h1234_5678, 32'd3);

    // Flush two cycles into an s=20 shift; a new accept follows directly.
    @(posedge clk); #1;
    start = 1'b1; op = 7'b0110011; func3 = 3'b001; func7_5 = 1'b0;
    operand_a = 32'h0000_00FF; shamt_src = 32'd20;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_done", 32'(done), 32'd0);
    issue(7'b0110011, 3'b101, 1'b1, 32'hF000_000F, 32'd8);
    check("post_flush", result, 32'hFFF0_0000);

    // Asynchronous reset in the middle of an s=31 shift.
    @(posedge clk); #1;
    start = 1'b1; op = 7'b0110011; func3 = 3'b001; func7_5 = 1'b0;
    operand_a = 32'h0000_0003; shamt_src = 32'd31;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_result", result, 32'h0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_stall", 32'(stall), 32'd0);
    exp_result = '0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(7'b0110011, 3'b001, 1'b0, 32'h0000_0001, 32'd1);
    check("post_rst", result, 32'h0000_0002);

    for (int i = 0; i < 60; i++) begin
      logic [6:0] o;
      logic [2:0] f3;
      int pick;
      pick = int'($urandom_range(0, 9));
      o  = (pick < 5) ? 7'b0110011 : (pick < 9) ? 7'b0010011 : 7'($urandom);
      f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom) : (($urandom_range(0, 1) == 0) ? 3'b001 : 3'b101);
      issue(o, f3, 1'($urandom), $urandom, $urandom);
    end

    @(posedge clk); #1;
    start = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got %h exp %h", 32'd0, 32'd1);
    $fatal(1, "bench timeout");
  end

endmodule
